// File: rtl/coin_pkg.sv
// coin_pkg
// Shared types for the coin acceptor slice: the 2-bit coin code presented
// to the downstream encoder, the acceptor FSM state, and a helper that maps
// a one-hot debounced button vector {Pen, HFa, Fa} onto its coin code.
package coin_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        HFA  = 2'b01,
        FA   = 2'b10,
        PEN  = 2'b11
    } coin_code_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        WAIT_REL,
        ERR
    } acc_state_t;

    // Only meaningful for a one-hot vector; anything else maps to NONE.
    function automatic coin_code_t code_of(input logic [2:0] pressed);
        case (pressed)
            3'b100:  return PEN;
            3'b010:  return HFA;
            3'b001:  return FA;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if
// Groups the raw button inputs, the coin valid/ack handshake and the status
// outputs of the coin acceptor.
//   slave  : the acceptor (buttons and coin_ack in; coin, error, count out)
//   master : the environment (drives buttons and coin_ack)
interface coin_acceptor_if;
    import coin_pkg::*;

    logic       Pen;
    logic       HFa;
    logic       Fa;
    logic       coin_ack;
    logic       coin_valid;
    coin_code_t coin_code;
    logic       multi_err;
    logic [7:0] coin_cnt;

    modport master (
        output Pen, HFa, Fa, coin_ack,
        input  coin_valid, coin_code, multi_err, coin_cnt
    );

    modport slave (
        input  Pen, HFa, Fa, coin_ack,
        output coin_valid, coin_code, multi_err, coin_cnt
    );

endinterface

// File: rtl/coin_debounce.sv
// coin_debounce
// One button channel: a SYNC_STAGES-deep synchroniser followed by a
// debounce counter. The stable output only flips after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   CLK50MHZ : board clock, rising edge
//   RES      : asynchronous active-high reset
//   noisy    : raw, bouncy, asynchronous button
//   stable   : debounced level
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2
) (
    input  logic CLK50MHZ,
    input  logic RES,
    input  logic noisy,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   stable_d, stable_q;
    logic                   sync_bit;

    // Any agreement between the synchronised input and the stable value
    // restarts the count, so only an unbroken run of disagreement flips it.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], noisy};
        sync_bit = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_bit != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_bit;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK50MHZ or posedge RES) begin
        if (RES) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor
// Debounces the three coin buttons and turns each physical press into at
// most one coin, presented with a valid/ack handshake. Presses of more than
// one button at once are rejected and flagged on multi_err.
// Ports:
//   CLK50MHZ : board clock, rising edge
//   RES      : asynchronous active-high reset
//   bus      : coin_acceptor_if.slave (Pen/HFa/Fa, coin_ack in;
//              coin_valid, coin_code, multi_err, coin_cnt out)
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2
) (
    input logic           CLK50MHZ,
    input logic           RES,
    coin_acceptor_if.slave bus
);

    logic       pen_stable, hfa_stable, fa_stable;
    logic [2:0] pressed_d, pressed_q;

    acc_state_t state_d, state_q;
    logic       coin_valid_d, coin_valid_q;
    coin_code_t coin_code_d, coin_code_q;
    logic       multi_err_d, multi_err_q;
    logic [7:0] coin_cnt_d, coin_cnt_q;

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) u_pen (.CLK50MHZ(CLK50MHZ), .RES(RES), .noisy(bus.Pen), .stable(pen_stable));

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) u_hfa (.CLK50MHZ(CLK50MHZ), .RES(RES), .noisy(bus.HFa), .stable(hfa_stable));

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) u_fa (.CLK50MHZ(CLK50MHZ), .RES(RES), .noisy(bus.Fa), .stable(fa_stable));

    // The three debounced levels are captured together in one register so
    // the FSM always judges single vs. multiple presses from one snapshot.
    assign pressed_d = {pen_stable, hfa_stable, fa_stable};

    // Next-state and next-output logic; outputs are registered alongside the
    // state so coin_valid/coin_code/multi_err are glitch-free.
    always_comb begin
        state_d      = state_q;
        coin_valid_d = 1'b0;
        coin_code_d  = NONE;
        multi_err_d  = 1'b0;
        coin_cnt_d   = coin_cnt_q;
        case (state_q)
            IDLE: begin
                if ($onehot(pressed_q)) begin
                    state_d      = PEND;
                    coin_valid_d = 1'b1;
                    coin_code_d  = code_of(pressed_q);
                end else if (pressed_q != 3'b000) begin
                    state_d     = ERR;
                    multi_err_d = 1'b1;
                end
            end
            PEND: begin
                // Button changes are ignored here; the latched coin is held
                // until the consumer takes it.
                coin_valid_d = 1'b1;
                coin_code_d  = coin_code_q;
                if (bus.coin_ack) begin
                    state_d      = WAIT_REL;
                    coin_valid_d = 1'b0;
                    coin_code_d  = NONE;
                    coin_cnt_d   = coin_cnt_q + 8'd1;
                end
            end
            WAIT_REL: begin
                if (pressed_q == 3'b000) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                multi_err_d = 1'b1;
                if (pressed_q == 3'b000) begin
                    state_d     = IDLE;
                    multi_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge RES) begin
        if (RES) begin
            pressed_q    <= 3'b000;
            state_q      <= IDLE;
            coin_valid_q <= 1'b0;
            coin_code_q  <= NONE;
            multi_err_q  <= 1'b0;
            coin_cnt_q   <= 8'd0;
        end else begin
            pressed_q    <= pressed_d;
            state_q      <= state_d;
            coin_valid_q <= coin_valid_d;
            coin_code_q  <= coin_code_d;
            multi_err_q  <= multi_err_d;
            coin_cnt_q   <= coin_cnt_d;
        end
    end

    assign bus.coin_valid = coin_valid_q;
    assign bus.coin_code  = coin_code_q;
    assign bus.multi_err  = multi_err_q;
    assign bus.coin_cnt   = coin_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
// Bench for coin_acceptor with a short debounce window. Stimulus tasks push
// the expected coin (or rejected multi-press) into a queue; a monitor pops
// an entry whenever a coin is handed over (valid and ack) or multi_err rises.
module tb_coin_acceptor;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [7:0] cnt;
    } exp_t;

    logic CLK50MHZ = 1'b0;
    logic RES      = 1'b0;

    coin_acceptor_if bus();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB), .CNT_W(19), .SYNC_STAGES(SYNC)
    ) dut (
        .CLK50MHZ(CLK50MHZ),
        .RES(RES),
        .bus(bus)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    exp_t       exp_q[$];
    int         checks     = 0;
    int         errors     = 0;
    logic [7:0] model_cnt  = 8'd0;
    int         total_acc  = 0;
    int         ack_mode   = 1;
    logic       watch_valid = 1'b0;
    int         valid_seen = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Coin code of each button as given by the coin table: Pen, HFa, Fa.
    function automatic logic [1:0] button_code(input int b);
        case (b)
            0:       return 2'b11;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic set_button(input int b, input logic v);
        case (b)
            0:       bus.Pen = v;
            1:       bus.HFa = v;
            default: bus.Fa  = v;
        endcase
    endtask

    task automatic release_all();
        bus.Pen = 1'b0;
        bus.HFa = 1'b0;
        bus.Fa  = 1'b0;
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge CLK50MHZ);
            #1;
        end
    endtask

    task automatic expect_coin(input int b);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = button_code(b);
        e.cnt    = model_cnt;
        exp_q.push_back(e);
        model_cnt++;
        total_acc++;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 2'b00;
        e.cnt    = model_cnt;
        exp_q.push_back(e);
    endtask

    // Pulses of 1-3 cycles separated by 1-3 low cycles: never long enough
    // to be accepted. Always ends low.
    task automatic bounce(input int b, input int min_cycles);
        int elapsed;
        int hi;
        int lo;
        elapsed = 0;
        while (elapsed < min_cycles) begin
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            set_button(b, 1'b1);
            step_n(hi);
            set_button(b, 1'b0);
            step_n(lo);
            elapsed += hi + lo;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step_n(1);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
        step_n(3);
    endtask

    // Watches coin_valid for exactly 11 edges starting at edge 0 (the edge
    // that first samples the new raw level); only edge 7 may show a coin.
    task automatic latency_check(input string name, input logic [1:0] code);
        for (int i = 0; i <= 10; i++) begin
            @(posedge CLK50MHZ);
            @(negedge CLK50MHZ);
            checkOutput(name, bus.coin_valid, (i == SYNC + DEB + 1));
            if (i == SYNC + DEB + 1) checkOutput({name, "_code"}, bus.coin_code, code);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus.coin_valid !== 1'b1 && n < 30) begin
            @(negedge CLK50MHZ);
            n++;
        end
        checkOutput(name, bus.coin_valid, 1);
    endtask

    // One randomized episode: 0 clean single, 1 bounce then single,
    // 2 staggered pair (first wins), 3 simultaneous multi-press, 4 glitch.
    task automatic applyStimulus(input int kind);
        int a;
        int b;
        int hold;
        a    = $urandom_range(0, 2);
        b    = (a + $urandom_range(1, 2)) % 3;
        hold = $urandom_range(10, 20);
        case (kind)
            0: begin
                set_button(a, 1'b1);
                expect_coin(a);
                step_n(hold);
            end
            1: begin
                bounce(a, 6);
                set_button(a, 1'b1);
                expect_coin(a);
                step_n(hold);
            end
            2: begin
                set_button(a, 1'b1);
                expect_coin(a);
                step_n($urandom_range(1, 3));
                set_button(b, 1'b1);
                step_n(hold);
            end
            3: begin
                set_button(a, 1'b1);
                set_button(b, 1'b1);
                if ($urandom_range(0, 1) == 1) set_button(3 - a - b, 1'b1);
                expect_err();
                step_n(hold);
            end
            default: begin
                bounce(a, $urandom_range(2, 8));
            end
        endcase
        release_all();
        step_n(12);
        drain("rand_drain");
        checkOutput("rand_coin_cnt", bus.coin_cnt, model_cnt);
    endtask

    // Ack driver: random, forced high or forced low.
    initial begin
        bus.coin_ack = 1'b0;
        forever begin
            @(posedge CLK50MHZ);
            #1;
            case (ack_mode)
                0:       bus.coin_ack = ($urandom_range(0, 1) == 1);
                1:       bus.coin_ack = 1'b1;
                default: bus.coin_ack = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per handed-over coin and per rising
    // multi_err, and compares code and count against it.
    initial begin
        exp_t e;
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge CLK50MHZ);
            if (watch_valid && bus.coin_valid === 1'b1) valid_seen++;
            if (bus.coin_valid === 1'b1 && bus.coin_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_coin actual code=%0h required=no coin at %0t", bus.coin_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("coin_is_err", 0, e.is_err);
                    checkOutput("coin_code", bus.coin_code, e.code);
                    checkOutput("coin_cnt_at_ack", bus.coin_cnt, e.cnt);
                end
            end
            if (bus.multi_err === 1'b1 && !prev_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_multi_err actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("err_is_err", 1, e.is_err);
                    checkOutput("err_cnt", bus.coin_cnt, e.cnt);
                end
            end
            prev_err = (bus.multi_err === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int bad;
        release_all();

        // Reset state
        #2 RES = 1'b1;
        step_n(3);
        checkOutput("rst_valid", bus.coin_valid, 0);
        checkOutput("rst_code", bus.coin_code, 0);
        checkOutput("rst_err", bus.multi_err, 0);
        checkOutput("rst_cnt", bus.coin_cnt, 0);
        RES = 1'b0;
        step_n(3);

        // 1: clean Fa with ack high, exact latency, no repeat while held
        $display("[TB] clean Fa press");
        ack_mode = 1;
        bus.Fa = 1'b1;
        expect_coin(2);
        latency_check("t1_valid_edge", 2'b10);
        watch_valid = 1'b1;
        valid_seen  = 0;
        step_n(20);
        watch_valid = 1'b0;
        checkOutput("t1_no_repeat", valid_seen, 0);
        checkOutput("t1_cnt1", bus.coin_cnt, 1);
        bus.Fa = 1'b0;
        step_n(12);
        bus.Fa = 1'b1;
        expect_coin(2);
        step_n(15);
        bus.Fa = 1'b0;
        step_n(12);
        drain("t1_drain");
        checkOutput("t1_cnt2", bus.coin_cnt, model_cnt);

        // 2: bouncing Pen then held
        $display("[TB] bouncing Pen");
        watch_valid = 1'b1;
        valid_seen  = 0;
        bounce(0, 20);
        watch_valid = 1'b0;
        checkOutput("t2_no_valid_bounce", valid_seen, 0);
        bus.Pen = 1'b1;
        expect_coin(0);
        step_n(15);
        bus.Pen = 1'b0;
        step_n(12);
        drain("t2_drain");
        checkOutput("t2_cnt", bus.coin_cnt, model_cnt);

        // 3: Pen and HFa on the same edge
        $display("[TB] simultaneous Pen+HFa");
        watch_valid = 1'b1;
        valid_seen  = 0;
        bus.Pen = 1'b1;
        bus.HFa = 1'b1;
        expect_err();
        step_n(20);
        watch_valid = 1'b0;
        checkOutput("t3_multi_err", bus.multi_err, 1);
        checkOutput("t3_no_valid", valid_seen, 0);
        checkOutput("t3_cnt", bus.coin_cnt, model_cnt);
        release_all();
        step_n(12);
        checkOutput("t3_err_clear", bus.multi_err, 0);
        drain("t3_drain");

        // 4: HFa held pending with ack low; Fa pressed meanwhile is ignored
        $display("[TB] HFa pending with ack low");
        ack_mode = 2;
        step_n(2);
        bus.HFa = 1'b1;
        expect_coin(1);
        wait_valid("t4_valid_rise");
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            step_n(1);
            if (c == 10) bus.Fa = 1'b1;
            if (c == 25) release_all();
            @(negedge CLK50MHZ);
            if (bus.coin_valid !== 1'b1 || bus.coin_code !== 2'b01) bad++;
        end
        checkOutput("t4_hold_bad_cycles", bad, 0);
        checkOutput("t4_cnt_before_ack", bus.coin_cnt, model_cnt - 8'd1);
        ack_mode = 1;
        drain("t4_drain");
        watch_valid = 1'b1;
        valid_seen  = 0;
        step_n(20);
        watch_valid = 1'b0;
        checkOutput("t4_no_second_coin", valid_seen, 0);
        checkOutput("t4_cnt", bus.coin_cnt, model_cnt);

        // 5: reset while a coin is pending
        $display("[TB] reset during pending coin");
        ack_mode = 2;
        step_n(2);
        bus.Pen = 1'b1;
        wait_valid("t5_valid_before_reset");
        #3 RES = 1'b1;
        #1;
        checkOutput("t5_async_valid", bus.coin_valid, 0);
        checkOutput("t5_async_code", bus.coin_code, 0);
        checkOutput("t5_async_err", bus.multi_err, 0);
        checkOutput("t5_async_cnt", bus.coin_cnt, 0);
        model_cnt = 8'd0;
        total_acc = 0;
        ack_mode  = 1;
        step_n(3);
        RES = 1'b0;
        expect_coin(0);
        latency_check("t5_valid_edge", 2'b11);
        bus.Pen = 1'b0;
        step_n(12);
        drain("t5_drain");
        checkOutput("t5_cnt", bus.coin_cnt, 1);

        // 6: randomized episodes until exactly 256 coins since reset
        $display("[TB] random episodes up to counter wrap");
        ack_mode = 0;
        while (total_acc < 256) begin
            applyStimulus($urandom_range(0, 4));
        end
        checkOutput("t6_wrap", bus.coin_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
